// File: rtl/uart_deframe_fifo.sv
// uart_deframe_fifo
// -----------------------------------------------------------------------------
// UART receive deframer with frame checking and output buffering.
// A completed serial frame (data_parll, qualified by receive_flag) is split
// into start / data / parity / stop fields. Parity and framing are checked,
// and {framing_err, parity_err, data} is queued in a DEPTH-entry FIFO that a
// consumer drains with a valid/ready handshake.
//
// Frame layout (LSB first on the wire):
//   bit 0                 start bit (must be 0)
//   [DATA_W:1]            data, LSB first
//   [DATA_W+1]            parity bit (only when PARITY_EN=1)
//   top STOP_W bits       stop bits (must all be 1)
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset; flushes the FIFO
//   receive_flag     one-cycle pulse, data_parll holds a complete frame
//   data_parll       parallel frame from the shift stage
//   out_ready        consumer accepts the head entry
//   out_valid        FIFO non-empty
//   data_out         head entry data
//   parity_err       head entry parity mismatch
//   framing_err      head entry start!=0 or any stop!=1
//   done_flag        one-cycle pulse, a frame was written into the FIFO
//   overrun          one-cycle pulse, a frame was dropped (FIFO full)
//   level            current occupancy, 0..DEPTH
//   parity_err_cnt   saturating count of queued frames with parity errors
//   framing_err_cnt  saturating count of queued frames with framing errors
//   overrun_cnt      saturating count of dropped frames
//
// Optional feature: define UART_DEFRAME_ERRCNT_EN to build the three 16-bit
// error counters. Without it the counter ports are tied to 0.
// -----------------------------------------------------------------------------
module uart_deframe_fifo #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_W     = 1,
  parameter int DEPTH      = 4,
  localparam int FRAME_W   = 1 + DATA_W + PARITY_EN + STOP_W,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               receive_flag,
  input  logic [FRAME_W-1:0] data_parll,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  data_out,
  output logic               parity_err,
  output logic               framing_err,
  output logic               done_flag,
  output logic               overrun,
  output logic [CNT_W-1:0]   level,
  output logic [15:0]        parity_err_cnt,
  output logic [15:0]        framing_err_cnt,
  output logic [15:0]        overrun_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] LEVEL_FULL = CNT_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Field split and checks
  // ---------------------------------------------------------------------------
  logic              start_bit;
  logic [DATA_W-1:0] rx_data;
  logic [STOP_W-1:0] stop_bits;
  logic              par_bit;
  logic              par_calc;
  logic              rx_parity_err;
  logic              rx_framing_err;

  assign start_bit = data_parll[0];
  assign rx_data   = data_parll[DATA_W:1];
  assign stop_bits = data_parll[FRAME_W-1 -: STOP_W];

  // Without a parity bit the position above the data belongs to the stop
  // field, so it must not be read as parity.
  generate
    if (PARITY_EN != 0) begin : g_par
      assign par_bit = data_parll[DATA_W+1];
    end else begin : g_nopar
      assign par_bit = 1'b0;
    end
  endgenerate

  assign par_calc       = (^rx_data) ^ 1'(PARITY_ODD);
  assign rx_parity_err  = (PARITY_EN != 0) && (par_calc != par_bit);
  assign rx_framing_err = start_bit | ~(&stop_bits);

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] wr_ent_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  always_comb begin
    full      = (level_q == LEVEL_FULL);
    empty     = (level_q == '0);
    pop       = ~empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push      = receive_flag & (~full | pop);
    wr_ent_d  = {rx_framing_err, rx_parity_err, rx_data};
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d   = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
    done_d    = push;
    overrun_d = receive_flag & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_ent_d;
    end
  end

  logic [ENT_W-1:0] head;
  assign head        = mem_q[rd_ptr_q];
  assign data_out    = head[DATA_W-1:0];
  assign parity_err  = head[DATA_W];
  assign framing_err = head[DATA_W+1];
  assign out_valid   = ~empty;
  assign level       = level_q;
  assign done_flag   = done_q;
  assign overrun     = overrun_q;

  // ---------------------------------------------------------------------------
  // Optional error counters (saturate at 0xFFFF)
  // ---------------------------------------------------------------------------
`ifdef UART_DEFRAME_ERRCNT_EN
  logic [15:0] perr_cnt_q, perr_cnt_d;
  logic [15:0] ferr_cnt_q, ferr_cnt_d;
  logic [15:0] ovr_cnt_q,  ovr_cnt_d;

  always_comb begin
    perr_cnt_d = perr_cnt_q;
    ferr_cnt_d = ferr_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    if (push && rx_parity_err && (perr_cnt_q != 16'hFFFF)) begin
      perr_cnt_d = perr_cnt_q + 16'd1;
    end
    if (push && rx_framing_err && (ferr_cnt_q != 16'hFFFF)) begin
      ferr_cnt_d = ferr_cnt_q + 16'd1;
    end
    if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_cnt_q <= '0;
      ferr_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      perr_cnt_q <= perr_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign parity_err_cnt  = perr_cnt_q;
  assign framing_err_cnt = ferr_cnt_q;
  assign overrun_cnt     = ovr_cnt_q;
`else
  assign parity_err_cnt  = 16'd0;
  assign framing_err_cnt = 16'd0;
  assign overrun_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_uart_deframe_fifo.sv
// Testbench for uart_deframe_fifo (DATA_W=8, PARITY_EN=1, STOP_W=1, DEPTH=4).
// Stimulus and checking are decoupled: the driver updates an abstract FIFO
// model and queues expected entries and expected per-cycle status; a monitor
// on the falling edge compares whatever the DUT presents.
module tb_uart_deframe_fifo;

  localparam int DEPTH = 4;

`ifdef UART_DEFRAME_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  typedef struct {
    int d;
    int pe;
    int fe;
  } ent_t;

  typedef struct {
    int tag;
    int done;
    int ov;
    int lvl;
    int pc;
    int fc;
    int oc;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        receive_flag;
  logic [10:0] data_parll;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  data_out;
  logic        parity_err;
  logic        framing_err;
  logic        done_flag;
  logic        overrun;
  logic [2:0]  level;
  logic [15:0] parity_err_cnt, framing_err_cnt, overrun_cnt;

  logic        o_rf, o_rdy;
  logic [10:0] o_dp;
  logic        o_valid, o_pe, o_fe, o_done, o_ov;
  logic [7:0]  o_data;
  logic [2:0]  o_lvl;
  logic [15:0] o_pc, o_fc, o_oc;

  always #5 clk = ~clk;

  uart_deframe_fifo #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_W(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .receive_flag(receive_flag), .data_parll(data_parll),
    .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out),
    .parity_err(parity_err), .framing_err(framing_err), .done_flag(done_flag),
    .overrun(overrun), .level(level), .parity_err_cnt(parity_err_cnt),
    .framing_err_cnt(framing_err_cnt), .overrun_cnt(overrun_cnt)
  );

  uart_deframe_fifo #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_W(1), .DEPTH(DEPTH)) u_odd (
    .clk(clk), .rst(rst), .receive_flag(o_rf), .data_parll(o_dp),
    .out_ready(o_rdy), .out_valid(o_valid), .data_out(o_data),
    .parity_err(o_pe), .framing_err(o_fe), .done_flag(o_done),
    .overrun(o_ov), .level(o_lvl), .parity_err_cnt(o_pc),
    .framing_err_cnt(o_fc), .overrun_cnt(o_oc)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  ent_t  sb[$];
  stat_t stq[$];

  int m_cnt = 0;
  int m_pc = 0, m_fc = 0, m_oc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected entry from the frame rules: even/odd parity over the data byte,
  // start must be 0, stop must be 1.
  function automatic ent_t model_frame(input int fr, input int odd);
    ent_t e;
    int ones, pbit, stop;
    e.d  = (fr >> 1) & 255;
    pbit = (fr >> 9) & 1;
    stop = (fr >> 10) & 1;
    ones = $countones(e.d);
    e.pe = (((ones + odd) % 2) != pbit) ? 1 : 0;
    e.fe = ((fr & 1) != 0 || stop != 1) ? 1 : 0;
    return e;
  endfunction

  // Drive one cycle; called just after a rising edge.
  task automatic step(input bit f, input int fr, input bit rdy, input bit r);
    stat_t s;
    bit pop_m, acc;
    receive_flag = f;
    data_parll   = 11'(fr);
    out_ready    = rdy;
    rst          = r;
    s.done = 0;
    s.ov   = 0;
    if (r) begin
      sb.delete();
      m_cnt = 0;
      m_pc = 0; m_fc = 0; m_oc = 0;
    end else begin
      pop_m = (m_cnt > 0) && rdy;
      acc   = f && ((m_cnt < DEPTH) || pop_m);
      if (acc) begin
        ent_t e;
        e = model_frame(fr, 0);
        sb.push_back(e);
        if (e.pe != 0 && m_pc < 65535) m_pc++;
        if (e.fe != 0 && m_fc < 65535) m_fc++;
        s.done = 1;
      end
      if (f && !acc) begin
        s.ov = 1;
        if (m_oc < 65535) m_oc++;
      end
      m_cnt = m_cnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
    end
    s.tag = cyc + 1;
    s.lvl = m_cnt;
    s.pc  = ERRCNT ? m_pc : 0;
    s.fc  = ERRCNT ? m_fc : 0;
    s.oc  = ERRCNT ? m_oc : 0;
    stq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  function automatic int clean_frame(input int d);
    int p;
    p = $countones(d & 255) % 2;
    return (1 << 10) | (p << 9) | ((d & 255) << 1);
  endfunction

  // Monitor: status after the previous edge, and handshakes about to occur.
  stat_t m_st;
  ent_t  m_e;
  always @(negedge clk) begin
    if (stq.size() > 0 && stq[0].tag == cyc) begin
      m_st = stq.pop_front();
      chk("level", int'(level), m_st.lvl);
      chk("out_valid", int'(out_valid), (m_st.lvl > 0) ? 1 : 0);
      chk("done_flag", int'(done_flag), m_st.done);
      chk("overrun", int'(overrun), m_st.ov);
      chk("parity_err_cnt", int'(parity_err_cnt), m_st.pc);
      chk("framing_err_cnt", int'(framing_err_cnt), m_st.fc);
      chk("overrun_cnt", int'(overrun_cnt), m_st.oc);
    end
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL pop_unexpected: got out_valid=1 expected no entry (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        chk("data_out", int'(data_out), m_e.d);
        chk("parity_err", int'(parity_err), m_e.pe);
        chk("framing_err", int'(framing_err), m_e.fe);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; receive_flag = 1'b0; data_parll = '0; out_ready = 1'b0;
    o_rf = 1'b0; o_dp = '0; o_rdy = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Clean frame
    step(1, 11'h54A, 0, 0);
    chk("clean_data", int'(data_out), 8'hA5);
    chk("clean_pe", int'(parity_err), 0);
    chk("clean_fe", int'(framing_err), 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Error flags travel with their data
    step(1, 11'h74A, 0, 0);
    chk("perr_head", int'(parity_err), 1);
    step(1, 11'h14A, 0, 0);
    step(1, 11'h54B, 0, 0);
    step(1, 11'h60E, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

    // Overrun: fifth push is dropped
    for (int i = 0; i < 5; i++) step(1, clean_frame(8'h10 + i), 0, 0);
    // Full with simultaneous push and pop
    step(1, clean_frame(8'h3C), 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

    // Reset mid-stream with a coincident receive_flag
    for (int i = 0; i < 3; i++) step(1, clean_frame(8'h70 + i), 0, 0);
    step(1, 11'h74A, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit f, rdy, r;
      int fr;
      f   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 5);
      r   = ($urandom_range(0, 199) == 0);
      fr  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2047))
                                        : clean_frame(int'($urandom_range(0, 255)));
      step(f, fr, rdy, r);
    end

    for (int i = 0; i < 20 && m_cnt > 0; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("scoreboard_empty", sb.size(), 0);

    // Odd parity instance
    o_rf = 1'b1; o_dp = 11'h74A;
    @(posedge clk); #1;
    o_dp = 11'h54A;
    @(posedge clk); #1;
    o_rf = 1'b0;
    chk("odd_level", int'(o_lvl), 2);
    chk("odd_data", int'(o_data), 8'hA5);
    chk("odd_pe_0x74A", int'(o_pe), 0);
    o_rdy = 1'b1;
    @(posedge clk); #1;
    o_rdy = 1'b0;
    chk("odd_pe_0x54A", int'(o_pe), 1);
    chk("odd_level_after_pop", int'(o_lvl), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_deframe_fifo.md
# uart_deframe_fifo

Parametrised UART receive deframer with frame checking and output buffering. It captures each completed serial frame from the shift stage as a parallel word, then splits it into start, data, parity and stop fields. It checks parity and framing, and queues the data byte with its error flags in a small FIFO drained by a valid/ready handshake. It sits between the receiver shift register and the host/register interface, replacing the purely combinational field split.

## Interface
- DATA_W, 8, data bits per frame (5..9)
- PARITY_EN, 1, 1 = frame carries a parity bit; 0 = no parity bit
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
- STOP_W, 1, number of stop bits (1 or 2)
- DEPTH, 4, FIFO entries (power of 2, 2..16)
- Derived: FRAME_W = 1 + DATA_W + PARITY_EN + STOP_W; CNT_W = clog2(DEPTH)+1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- receive_flag  in  1  one-cycle pulse: data_parll holds a complete frame
- data_parll  in  FRAME_W  frame layout:
  - bit0 = start bit
  - [DATA_W:1] = data, LSB first
  - [DATA_W+1] = parity (if PARITY_EN)
  - top STOP_W bits = stop bits
- out_ready  in  1  consumer accepts head entry
- out_valid  out  1  FIFO non-empty
- data_out  out  DATA_W  head entry data
- parity_err  out  1  head entry parity mismatch
- framing_err  out  1  head entry start!=0 or any stop!=1
- done_flag  out  1  one-cycle pulse: a frame was written into the FIFO
- overrun  out  1  one-cycle pulse: a frame was dropped, FIFO full
- level  out  CNT_W  current entry count
- parity_err_cnt, framing_err_cnt, overrun_cnt  out  16 each  error counters (see Configuration)

## Operation
- Push: on receive_flag, extract the fields combinationally, compute the error flags, and write {framing_err, parity_err, data} at wr_ptr.
- Parity check: p = XOR(data) ^ PARITY_ODD; parity_err = PARITY_EN & (p != parity bit).
- Framing check: framing_err = (start != 0) | (any stop bit == 0).
- Frames with errors are still queued. The flags travel with their data.
- Pop: out_valid & out_ready advances rd_ptr. data_out, parity_err and framing_err always reflect the head entry; they are don't-care when out_valid=0.
- Full, push without pop: frame dropped, overrun pulses, FIFO contents and pointers unchanged, done_flag stays 0.
- Full, push and pop in the same cycle: both occur, level unchanged, done_flag=1, no overrun.
- Empty, push: out_valid rises next cycle. No same-cycle bypass.
- Empty, out_ready high: no effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is the explicit occupancy counter (0..DEPTH).

## Timing
- Reset values: out_valid=0, level=0, done_flag=0, overrun=0, pointers=0, counters=0. data_out, parity_err and framing_err read the entry at index 0.
- Latency: receive_flag at edge N -> entry visible with out_valid=1 after edge N+1 (when the FIFO was empty).
- done_flag and overrun are registered. They are high for exactly the one cycle after the qualifying receive_flag edge.
- A pop takes effect at the accepting edge. The next entry, if any, is presented in the following cycle with no bubble.
- Back-to-back receive_flag pulses on every cycle are supported, up to DEPTH frames without a pop.
- rst mid-operation flushes all entries at the next edge. A receive_flag coincident with rst is discarded.

## Configuration
- Macro UART_DEFRAME_ERRCNT_EN.
- Defined: three 16-bit saturating counters that hold at 0xFFFF.
  - parity_err_cnt: increments on each push with parity_err.
  - framing_err_cnt: increments on each push with framing_err.
  - overrun_cnt: increments on each dropped frame.
  - All three clear on rst.
- Not defined: the counter ports remain and are tied to 0, and no counter logic is built.

## Test plan
All scenarios use DATA_W=8, PARITY_EN=1, PARITY_ODD=0, STOP_W=1, DEPTH=4, so FRAME_W=11.
- Clean frame: receive_flag with data_parll=0x54A -> the next cycle shows out_valid=1, data_out=0xA5, parity_err=0, framing_err=0, done_flag pulse, level=1.
- Error flags: push 0x74A -> data_out=0xA5 with parity_err=1. Push 0x14A -> framing_err=1. Push 0x54B -> framing_err=1. Push 0x60E -> data_out=0x07 with no errors.
- Overrun: with out_ready=0, push 5 frames -> level=4, the 5th push gives an overrun pulse and no done_flag. Draining returns the first 4 frames in order. With the macro defined, overrun_cnt=1.
- Full with push+pop: FIFO full, receive_flag and out_ready in the same cycle -> level stays 4, done_flag=1, no overrun. The new frame emerges last.
- Reset mid-stream: with 3 entries queued, assert rst for 1 cycle alongside a receive_flag -> out_valid=0, level=0, no done_flag, and counters at 0.
- Odd parity variant: with PARITY_ODD=1, frame 0x74A -> parity_err=0, and frame 0x54A -> parity_err=1.
